// File: rtl/cmult_share_arb.sv
// cmult_share_arb
//   Shares one pipelined complex multiplier (conj(a)*b, fixed latency) between
//   two requesters with packet-locked round-robin ownership. A grant lasts until
//   the owner's last beat is accepted or the hold limit expires. Results are
//   steered back to the issuing requester by a {valid,id} tag pipeline that runs
//   in lockstep with the multiplier latency.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   reqX_valid/last/ar/ai/br/bi  requester X beat (X = 0,1)
//   reqX_ready                 requester X owns the multiplier this cycle
//   m_en, m_ar/ai/br/bi        registered operands to the multiplier
//   m_en_dd, m_pr/m_pi         multiplier result and its valid
//   rspX_valid                 one-cycle result pulse for requester X
//   rsp_pr/rsp_pi              result data shared by both response channels
//   err                        sticky: m_en_dd disagreed with the tag pipeline
//   fsm_state                  arbiter state for observation (IDLE/OWN0/OWN1)
//
// Handshake: a beat transfers on a cycle where reqX_valid & reqX_ready are both
// high; valid may drop at any time, ready depends only on the current owner and
// is never high in IDLE. Responses have no backpressure.
//
// MULT_LAT must be at least 2.
module cmult_share_arb #(
  parameter int Q        = 16,
  parameter int MULT_LAT = 6,
  parameter int MAX_HOLD = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic         req0_last,
  input  logic [Q-1:0] req0_ar,
  input  logic [Q-1:0] req0_ai,
  input  logic [Q-1:0] req0_br,
  input  logic [Q-1:0] req0_bi,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic         req1_last,
  input  logic [Q-1:0] req1_ar,
  input  logic [Q-1:0] req1_ai,
  input  logic [Q-1:0] req1_br,
  input  logic [Q-1:0] req1_bi,
  output logic         req1_ready,
  output logic         m_en,
  output logic [Q-1:0] m_ar,
  output logic [Q-1:0] m_ai,
  output logic [Q-1:0] m_br,
  output logic [Q-1:0] m_bi,
  input  logic         m_en_dd,
  input  logic [Q-1:0] m_pr,
  input  logic [Q-1:0] m_pi,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [Q-1:0] rsp_pr,
  output logic [Q-1:0] rsp_pi,
  output logic         err,
  output logic [1:0]   fsm_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  logic [1:0]          state, state_nxt;
  logic                rr_pref, rr_nxt;     // 0: req0 preferred on a tie
  logic [HW-1:0]       hold_cnt;
  logic                m_id;
  logic [MULT_LAT-1:0] tag_v, tag_id;

  logic                owning, owner_sel;
  logic                own_valid, own_last, other_valid;
  logic [Q-1:0]        own_ar, own_ai, own_br, own_bi;
  logic                accept, terminate;

  assign owning      = (state == OWN0) || (state == OWN1);
  assign owner_sel   = (state == OWN1);
  assign own_valid   = owner_sel ? req1_valid : req0_valid;
  assign own_last    = owner_sel ? req1_last  : req0_last;
  assign other_valid = owner_sel ? req0_valid : req1_valid;
  assign own_ar      = owner_sel ? req1_ar : req0_ar;
  assign own_ai      = owner_sel ? req1_ai : req0_ai;
  assign own_br      = owner_sel ? req1_br : req0_br;
  assign own_bi      = owner_sel ? req1_bi : req0_bi;

  assign req0_ready  = (state == OWN0);
  assign req1_ready  = (state == OWN1);
  assign accept      = owning && own_valid;
  // The hold limit counts owned clocks, not beats, so an owner that idles
  // mid-packet still releases the multiplier eventually.
  assign terminate   = owning && ((accept && own_last) || (hold_cnt == HOLD_LAST));
  assign fsm_state   = state;

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_pref;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) state_nxt = rr_pref ? OWN1 : OWN0;
        else if (req0_valid)          state_nxt = OWN0;
        else if (req1_valid)          state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        if (terminate) begin
          rr_nxt    = ~owner_sel;
          // Hand straight over when the other side is waiting: no bubble.
          state_nxt = other_valid ? (owner_sel ? OWN0 : OWN1) : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_pref    <= 1'b0;
      hold_cnt   <= '0;
      m_en       <= 1'b0;
      m_id       <= 1'b0;
      m_ar       <= '0;
      m_ai       <= '0;
      m_br       <= '0;
      m_bi       <= '0;
      tag_v      <= '0;
      tag_id     <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_pr     <= '0;
      rsp_pi     <= '0;
      err        <= 1'b0;
    end else begin
      state    <= state_nxt;
      rr_pref  <= rr_nxt;
      hold_cnt <= (owning && !terminate) ? hold_cnt + 1'b1 : '0;

      m_en <= accept;
      if (accept) begin
        m_id <= owner_sel;
        m_ar <= own_ar;
        m_ai <= own_ai;
        m_br <= own_br;
        m_bi <= own_bi;
      end

      // Tag enters alongside m_en, so the last stage lines up with m_en_dd.
      tag_v  <= {tag_v[MULT_LAT-2:0], m_en};
      tag_id <= {tag_id[MULT_LAT-2:0], m_id};

      rsp0_valid <= m_en_dd && tag_v[MULT_LAT-1] && !tag_id[MULT_LAT-1];
      rsp1_valid <= m_en_dd && tag_v[MULT_LAT-1] &&  tag_id[MULT_LAT-1];
      if (m_en_dd) begin
        rsp_pr <= m_pr;
        rsp_pi <= m_pi;
      end

      if (m_en_dd != tag_v[MULT_LAT-1]) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmult_share_arb.sv
`timescale 1ns/1ps
module tb_cmult_share_arb;
  localparam int Q    = 16;
  localparam int L    = 6;
  localparam int MH   = 8;
  localparam int QDEC = 9;
  localparam int EW   = 32 + 1 + 2*Q;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         v[2], lst[2];
  logic [Q-1:0] ar[2], ai[2], br[2], bi[2];
  logic         req0_ready, req1_ready, m_en, m_en_dd;
  logic [Q-1:0] m_ar, m_ai, m_br, m_bi, m_pr, m_pi, rsp_pr, rsp_pi;
  logic         rsp0_valid, rsp1_valid, err;
  logic [1:0]   fsm_state;
  logic         force_dd = 1'b0;

  cmult_share_arb #(.Q(Q), .MULT_LAT(L), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v[0]), .req0_last(lst[0]), .req0_ar(ar[0]), .req0_ai(ai[0]),
    .req0_br(br[0]), .req0_bi(bi[0]), .req0_ready(req0_ready),
    .req1_valid(v[1]), .req1_last(lst[1]), .req1_ar(ar[1]), .req1_ai(ai[1]),
    .req1_br(br[1]), .req1_bi(bi[1]), .req1_ready(req1_ready),
    .m_en(m_en), .m_ar(m_ar), .m_ai(m_ai), .m_br(m_br), .m_bi(m_bi),
    .m_en_dd(m_en_dd), .m_pr(m_pr), .m_pi(m_pi),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_pr(rsp_pr), .rsp_pi(rsp_pi), .err(err), .fsm_state(fsm_state)
  );

  // conj(a)*b in Q.9
  function automatic logic [Q-1:0] c_re(input logic signed [Q-1:0] a_r, a_i, b_r, b_i);
    longint t;
    t = longint'(a_r) * longint'(b_r) + longint'(a_i) * longint'(b_i);
    return Q'(t >>> QDEC);
  endfunction
  function automatic logic [Q-1:0] c_im(input logic signed [Q-1:0] a_r, a_i, b_r, b_i);
    longint t;
    t = longint'(a_r) * longint'(b_i) - longint'(a_i) * longint'(b_r);
    return Q'(t >>> QDEC);
  endfunction

  // ---------------- multiplier model (shares rst_n) ----------------
  logic [L-1:0] mp_v;
  logic [Q-1:0] mp_pr[L], mp_pi[L];
  bit seen_rst = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      seen_rst <= 1;
      mp_v <= '0;
      for (int i = 0; i < L; i++) begin mp_pr[i] <= '0; mp_pi[i] <= '0; end
    end else begin
      mp_v     <= {mp_v[L-2:0], m_en};
      mp_pr[0] <= c_re(m_ar, m_ai, m_br, m_bi);
      mp_pi[0] <= c_im(m_ar, m_ai, m_br, m_bi);
      for (int i = 1; i < L; i++) begin mp_pr[i] <= mp_pr[i-1]; mp_pi[i] <= mp_pi[i-1]; end
    end
  end
  assign m_en_dd = mp_v[L-1] | force_dd;
  assign m_pr    = mp_pr[L-1];
  assign m_pi    = mp_pi[L-1];

  // ---------------- scoreboard ----------------
  int checks = 0, failures = 0;
  int cyc = 0;
  int cnt_rsp0 = 0, cnt_rsp1 = 0, cnt_men = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // behavioural arbiter/result model: owner (-1 none), tie preference, owned clocks
  int           own = -1, pref = 0, used = 0;
  logic         exp_men = 0, exp_err = 0;
  logic [Q-1:0] exp_m[4] = '{default: '0};
  logic [EW-1:0] exp_q[$];   // {due cycle, id, pr, pi} in issue order

  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic er0, er1;
    int acc;
    cyc++;
    if (seen_rst) begin
      check("req0_ready", req0_ready, own == 0);
      check("req1_ready", req1_ready, own == 1);
      check("m_en", m_en, exp_men);
      check("m_ar", m_ar, exp_m[0]);
      check("m_ai", m_ai, exp_m[1]);
      check("m_br", m_br, exp_m[2]);
      check("m_bi", m_bi, exp_m[3]);
      er0 = 0; er1 = 0;
      if (exp_q.size() > 0 && exp_q[0][EW-1:EW-32] == 32'(cyc)) begin
        e = exp_q.pop_front();
        if (e[2*Q]) er1 = 1; else er0 = 1;
        check("rsp_pr", rsp_pr, e[2*Q-1:Q]);
        check("rsp_pi", rsp_pi, e[Q-1:0]);
      end
      check("rsp0_valid", rsp0_valid, er0);
      check("rsp1_valid", rsp1_valid, er1);
      check("err", err, exp_err);
      cnt_rsp0 += int'(rsp0_valid);
      cnt_rsp1 += int'(rsp1_valid);
      cnt_men  += int'(m_en);
    end
    // advance the model across the coming clock edge
    if (!rst_n) begin
      own = -1; pref = 0; used = 0; exp_men = 0; exp_err = 0;
      exp_m = '{default: '0};
      exp_q.delete();
    end else begin
      if (force_dd && !(exp_q.size() > 0 && exp_q[0][EW-1:EW-32] == 32'(cyc + 1)))
        exp_err = 1;
      acc = (own >= 0 && v[own]) ? own : -1;
      exp_men = (acc >= 0);
      if (acc >= 0) begin
        exp_m = '{ar[acc], ai[acc], br[acc], bi[acc]};
        exp_q.push_back({32'(cyc + L + 2), 1'(acc),
                         c_re(ar[acc], ai[acc], br[acc], bi[acc]),
                         c_im(ar[acc], ai[acc], br[acc], bi[acc])});
      end
      if (own < 0) begin
        if (v[0] && v[1]) own = pref;
        else if (v[0])    own = 0;
        else if (v[1])    own = 1;
        used = 0;
      end else if ((acc >= 0 && lst[own]) || used == MH - 1) begin
        pref = 1 - own;
        own  = v[pref] ? pref : -1;
        used = 0;
      end else begin
        used++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk); #1;
  endtask

  function automatic logic rdy(input int id);
    return id ? req1_ready : req0_ready;
  endfunction

  task automatic drive_beat(input int id, input logic last, input bit fixed);
    v[id] = 1; lst[id] = last;
    if (fixed) begin ar[id] = 512; ai[id] = 0; br[id] = 256; bi[id] = 128; end
    else begin
      ar[id] = Q'($urandom); ai[id] = Q'($urandom);
      br[id] = Q'($urandom); bi[id] = Q'($urandom);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
  endtask

  // Sends an nb-beat packet with last on the final beat; optionally drops
  // valid for gap_len clocks once gap_at beats have been accepted.
  task automatic send_pkt(input int id, input int nb, input int gap_at, input int gap_len,
                          input bit fixed, output int first_hs, output int last_hs);
    int n = 0, g = 0, budget = 0;
    first_hs = -1; last_hs = -1;
    @(posedge clk); #1 drive_beat(id, nb == 1, fixed);
    while (n < nb && budget < 200) begin
      step(); budget++;
      if (v[id] && rdy(id)) begin
        if (n == 0) first_hs = cyc;
        last_hs = cyc; n++;
      end
      if (n == nb) break;
      @(posedge clk); #1;
      if (n == gap_at && g < gap_len) begin v[id] = 0; g++; end
      else drive_beat(id, n == nb - 1, fixed);
    end
    @(posedge clk); #1 v[id] = 0; lst[id] = 0;
    check("pkt_beats", n, nb);
  endtask

  task automatic drain();
    repeat (L + 6) step();
  endtask

  // ---------------- tests ----------------
  int f0, l0, f1, l1, f0b, l0b, run, b0, b1, bm;

  initial begin
    for (int i = 0; i < 2; i++) begin
      v[i] = 0; lst[i] = 0; ar[i] = 0; ai[i] = 0; br[i] = 0; bi[i] = 0;
    end
    @(posedge clk); step();
    check("rst_ready0", req0_ready, 0);
    check("rst_m_en", m_en, 0);
    check("rst_rsp0", rsp0_valid, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1 rst_n = 1;

    // 1: req0 only, fixed operands, 4 beats
    b0 = cnt_rsp0; b1 = cnt_rsp1;
    send_pkt(0, 4, -1, 0, 1, f0, l0);
    if (f0 >= 0) begin
      while (cyc < f0 + 8) step();
      check("t1_first_rsp_valid", rsp0_valid, 1);
      check("t1_first_rsp_pr", rsp_pr, 256);
      check("t1_first_rsp_pi", rsp_pi, 128);
    end
    drain();
    check("t1_rsp0_count", cnt_rsp0 - b0, 4);
    check("t1_rsp1_count", cnt_rsp1 - b1, 0);
    check("t1_last_pr", rsp_pr, 256);

    // 2: both valid right after reset
    do_reset();
    fork
      begin send_pkt(0, 3, -1, 0, 0, f0, l0); send_pkt(0, 3, -1, 0, 0, f0b, l0b); end
      send_pkt(1, 3, -1, 0, 0, f1, l1);
    join
    check("t2_req0_first", f0 < f1, 1);
    check("t2_req1_after_last", f1, l0 + 1);
    check("t2_req0_again", f0b, l1 + 1);
    drain();

    // 3: hold limit
    fork
      send_pkt(0, 12, -1, 0, 0, f0, l0);
      begin @(posedge clk); send_pkt(1, 3, -1, 0, 0, f1, l1); end
      begin
        for (int k = 0; k < 20 && !req0_ready; k++) step();
        run = 0;
        while (req0_ready && run < 50) begin run++; step(); end
        check("t3_hold_run", run, MH);
      end
    join
    check("t3_req1_after_hold", f1, f0 + MH);
    check("t3_req0_resumes", l0 > l1, 1);
    drain();

    // 4: valid gap mid-packet
    b0 = cnt_rsp0; b1 = cnt_rsp1; bm = cnt_men;
    send_pkt(0, 4, 2, 3, 0, f0, l0);
    drain();
    check("t4_span", l0 - f0, 6);
    check("t4_m_en_count", cnt_men - bm, 4);
    check("t4_rsp0_count", cnt_rsp0 - b0, 4);
    check("t4_rsp1_count", cnt_rsp1 - b1, 0);

    // 5: m_en_dd without a tag
    @(posedge clk); #1 force_dd = 1;
    @(posedge clk); #1 force_dd = 0;
    step();
    check("t5_err_set", err, 1);
    repeat (3) begin step(); check("t5_err_sticky", err, 1); end
    do_reset();
    step();
    check("t5_err_cleared", err, 0);

    // 6: reset mid-burst
    repeat (8) begin
      @(posedge clk); #1 drive_beat(0, 0, 0); drive_beat(1, 0, 0);
    end
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1; v[0] = 0; v[1] = 0;
    step();
    check("t6_ready0", req0_ready, 0);
    check("t6_ready1", req1_ready, 0);
    check("t6_m_en", m_en, 0);
    check("t6_m_ar", m_ar, 0);
    check("t6_rsp_pr", rsp_pr, 0);
    check("t6_rsp_pi", rsp_pi, 0);
    b0 = cnt_rsp0; b1 = cnt_rsp1;
    drain(); drain();
    check("t6_no_rsp", (cnt_rsp0 - b0) + (cnt_rsp1 - b1), 0);
    check("t6_err", err, 0);

    // random phase
    repeat (2000) begin
      @(posedge clk); #1;
      rst_n = ($urandom_range(0, 399) != 0);
      for (int i = 0; i < 2; i++) begin
        drive_beat(i, $urandom_range(0, 4) == 0, 0);
        v[i] = ($urandom_range(0, 3) != 0);
      end
    end
    @(posedge clk); #1 rst_n = 1; v[0] = 0; v[1] = 0; lst[0] = 0; lst[1] = 0;
    drain(); drain();
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
